// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle RV32IM ALU: op codes, FSM states and
// op-class helpers.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLT    = 5'd2,
    ALU_SLTU   = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_OR     = 5'd5,
    ALU_AND    = 5'd6,
    ALU_SLL    = 5'd7,
    ALU_SRL    = 5'd8,
    ALU_SRA    = 5'd9,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } alu_state_e;

  function automatic logic is_mul(input logic [4:0] op);
    return (op >= 5'd16) && (op <= 5'd19);
  endfunction

  function automatic logic is_div(input logic [4:0] op);
    return (op >= 5'd20) && (op <= 5'd23);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus of alu_mc: the core drives the request side (master),
// the ALU drives ready/valid/result (slave).
interface alu_mc_if #(
  parameter int XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_op_a;
  logic [XLEN-1:0] i_op_b;
  logic [4:0]      i_alu_op;
  logic            o_valid;
  logic [XLEN-1:0] o_alu_data;
  logic            o_busy;

  modport master (
    output i_valid, i_op_a, i_op_b, i_alu_op,
    input  o_ready, o_valid, o_alu_data, o_busy
  );

  modport slave (
    input  i_valid, i_op_a, i_op_b, i_alu_op,
    output o_ready, o_valid, o_alu_data, o_busy
  );
endinterface

// File: rtl/alu_divider.sv
// Iterative restoring divider: XLEN steps on magnitudes, signs and the
// divide-by-zero case fixed combinationally on the last step.
module alu_divider
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            signed_i,
  input  logic            rem_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q, orig_q;
  logic            qneg_q, rneg_q, want_rem_q, div0_q;

  logic            dvd_neg, dvs_neg, ge;
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_n, quo_n, q_fin, r_fin;

  assign dvd_neg = signed_i && dividend_i[XLEN-1];
  assign dvs_neg = signed_i && divisor_i[XLEN-1];

  // One restoring step: shift next dividend bit into the partial remainder
  // and keep the subtraction only if it did not borrow.
  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    quo_n   = {quo_q[XLEN-2:0], ge};
    q_fin   = qneg_q ? -quo_n : quo_n;
    r_fin   = rneg_q ? -rem_n : rem_n;
    if (div0_q) begin
      q_fin = '1;
      r_fin = orig_q;
    end
    result_o = want_rem_q ? r_fin : q_fin;
  end

  assign done_o = busy_q && (cnt_q == CW'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      orig_q     <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      want_rem_q <= 1'b0;
      div0_q     <= 1'b0;
    end else if (start_i) begin
      busy_q     <= 1'b1;
      cnt_q      <= CW'(XLEN);
      rem_q      <= '0;
      quo_q      <= dvd_neg ? -dividend_i : dividend_i;
      dvs_q      <= dvs_neg ? -divisor_i : divisor_i;
      orig_q     <= dividend_i;
      qneg_q     <= dvd_neg ^ dvs_neg;
      rneg_q     <= dvd_neg;
      want_rem_q <= rem_i;
      div0_q     <= (divisor_i == '0);
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32IM execute ALU: base ops in 1 cycle, M-extension ops on an
// iterative datapath. Define ALU_FAST_MUL_EN for a single-cycle multiplier.
module alu_mc
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic     i_clk,
  input logic     i_reset,
  alu_mc_if.slave bus
);
  localparam int SHAMT_W = $clog2(XLEN);
  localparam int CW      = $clog2(XLEN) + 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MUL  = ST_MUL;
  localparam logic [1:0] S_DIV  = ST_DIV;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    data_q, data_d;

  logic [4:0]         op;
  logic [XLEN-1:0]    a, b, base_res;
  logic [SHAMT_W-1:0] shamt;
  logic               accept, dv_start, dv_done;
  logic [XLEN-1:0]    dv_res;

  assign op     = bus.i_alu_op;
  assign a      = bus.i_op_a;
  assign b      = bus.i_op_b;
  assign shamt  = b[SHAMT_W-1:0];
  assign accept = bus.i_valid && (state_q == S_IDLE);

`ifdef ALU_FAST_MUL_EN
  logic signed [XLEN:0]     fa, fb;
  logic signed [2*XLEN+1:0] fprod;
  assign fa    = {((op == ALU_MULH) || (op == ALU_MULHSU)) && a[XLEN-1], a};
  assign fb    = {(op == ALU_MULH) && b[XLEN-1], b};
  assign fprod = fa * fb;
`endif

  always_comb begin
    base_res = '0;
    case (op)
      ALU_ADD:  base_res = a + b;
      ALU_SUB:  base_res = a - b;
      ALU_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  base_res = a ^ b;
      ALU_OR:   base_res = a | b;
      ALU_AND:  base_res = a & b;
      ALU_SLL:  base_res = a << shamt;
      ALU_SRL:  base_res = a >> shamt;
      ALU_SRA:  base_res = $signed(a) >>> shamt;
      default:  base_res = '0;
    endcase
`ifdef ALU_FAST_MUL_EN
    if (is_mul(op)) base_res = (op == ALU_MUL) ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif
  end

`ifndef ALU_FAST_MUL_EN
  // Shift-add multiplier on magnitudes; low half of prod_q starts as the
  // multiplier and is consumed one bit per step.
  logic [2*XLEN-1:0] prod_q, prod_nx, prod_fin;
  logic [XLEN-1:0]   mcand_q, mag_a, mag_b, mul_res;
  logic              mneg_q, mhi_q, a_neg, b_neg;
  logic [XLEN:0]     psum;

  always_comb begin
    a_neg    = ((op == ALU_MULH) || (op == ALU_MULHSU)) && a[XLEN-1];
    b_neg    = (op == ALU_MULH) && b[XLEN-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    psum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nx  = {psum, prod_q[XLEN-1:1]};
    prod_fin = mneg_q ? -prod_nx : prod_nx;
    mul_res  = mhi_q ? prod_fin[2*XLEN-1:XLEN] : prod_fin[XLEN-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prod_q  <= '0;
      mcand_q <= '0;
      mneg_q  <= 1'b0;
      mhi_q   <= 1'b0;
    end else if (accept && is_mul(op)) begin
      prod_q  <= {{XLEN{1'b0}}, mag_b};
      mcand_q <= mag_a;
      mneg_q  <= a_neg ^ b_neg;
      mhi_q   <= (op != ALU_MUL);
    end else if (state_q == S_MUL) begin
      prod_q  <= prod_nx;
    end
  end
`endif

  assign dv_start = accept && is_div(op);

  alu_divider #(.XLEN(XLEN)) u_div (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .start_i    (dv_start),
    .signed_i   ((op == ALU_DIV) || (op == ALU_REM)),
    .rem_i      ((op == ALU_REM) || (op == ALU_REMU)),
    .dividend_i (a),
    .divisor_i  (b),
    .done_o     (dv_done),
    .result_o   (dv_res)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    data_d  = data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (is_div(op)) begin
          state_d = S_DIV;
          cnt_d   = CW'(XLEN);
`ifndef ALU_FAST_MUL_EN
        end else if (is_mul(op)) begin
          state_d = S_MUL;
          cnt_d   = CW'(XLEN);
`endif
        end else begin
          valid_d = 1'b1;
          data_d  = base_res;
        end
      end
`ifndef ALU_FAST_MUL_EN
      S_MUL: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = mul_res;
        end
      end
`endif
      S_DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (dv_done) begin
          state_d = S_IDLE;
          valid_d = 1'b1;
          data_d  = dv_res;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign bus.o_ready    = (state_q == S_IDLE);
  assign bus.o_busy     = (state_q != S_IDLE);
  assign bus.o_valid    = valid_q;
  assign bus.o_alu_data = data_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed + random bench for alu_mc (XLEN=32) against a 64-bit arithmetic
// reference model.
module tb_alu_mc;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  alu_mc_if #(.XLEN(XLEN)) bus ();

  alu_mc #(.XLEN(XLEN)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd3:  return (a < b) ? 32'd1 : 32'd0;
      5'd4:  return a ^ b;
      5'd5:  return a | b;
      5'd6:  return a & b;
      5'd7:  return a << b[4:0];
      5'd8:  return a >> b[4:0];
      5'd9:  return $signed(a) >>> b[4:0];
      5'd16: begin up = ua * ub; return up[31:0]; end
      5'd17: begin sp = sa * sb; return sp[63:32]; end
      5'd18: begin sp = sa * $signed(ub); return sp[63:32]; end
      5'd19: begin up = ua * ub; return up[63:32]; end
      5'd20: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      5'd21: return (b == 0) ? 32'hFFFFFFFF : a / b;
      5'd22: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      5'd23: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int lat_of(input logic [4:0] op);
    if (op >= 5'd20 && op <= 5'd23) return XLEN + 1;
`ifdef ALU_FAST_MUL_EN
    return 1;
`else
    if (op >= 5'd16 && op <= 5'd19) return XLEN + 1;
    return 1;
`endif
  endfunction

  // Issue one op from idle, then measure latency, ready-low cycles and result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int lat, nrdy;
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = op; bus.i_op_a = a; bus.i_op_b = b;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 1; nrdy = 0;
    while (!bus.o_valid && lat < 100) begin
      if (!bus.o_ready) nrdy++;
      @(negedge clk);
      lat++;
    end
    check({tag, ".valid"}, 64'(bus.o_valid), 64'd1);
    check({tag, ".lat"}, 64'(lat), 64'(lat_of(op)));
    check({tag, ".ready_low"}, 64'(nrdy), 64'(lat_of(op) - 1));
    check({tag, ".data"}, 64'(bus.o_alu_data), 64'(exp));
    check({tag, ".ready_at_valid"}, 64'(bus.o_ready), 64'd1);
  endtask

  initial begin
    int vcount, lat;
    logic [4:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  codes [19];
    for (int i = 0; i < 10; i++) codes[i] = 5'(i);
    for (int i = 0; i < 8; i++) codes[10+i] = 5'(16 + i);
    codes[18] = 5'd31;

    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_alu_op = '0; bus.i_op_a = '0; bus.i_op_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.valid", 64'(bus.o_valid), 64'd0);
    check("rst.data", 64'(bus.o_alu_data), 64'd0);
    check("rst.busy", 64'(bus.o_busy), 64'd0);
    check("rst.ready", 64'(bus.o_ready), 64'd1);

    // Base ops and corners with constant expectations
    run_op(5'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, "add_ovf");
    run_op(5'd9, 32'h80000000, 32'd4, 32'hF8000000, "sra");
    run_op(5'd3, 32'd1, 32'hFFFFFFFF, 32'd1, "sltu");
    run_op(5'd17, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
    run_op(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run_op(5'd16, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
    run_op(5'd20, 32'd7, 32'd0, 32'hFFFFFFFF, "div0");
    run_op(5'd23, 32'd7, 32'd0, 32'd7, "remu0");
    run_op(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
    run_op(5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div_neg");
    run_op(5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem_neg");
    run_op(5'd31, 32'd123, 32'd456, 32'd0, "illegal");
    check("illegal.busy", 64'(bus.o_busy), 64'd0);

    // Back-to-back base ops: one result per cycle
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("b2b.valid", 64'(bus.o_valid), 64'd1);
        check("b2b.data", 64'(bus.o_alu_data), 64'(32'(i - 1) * 32'd10 + 32'd1));
      end
      if (i < 4) begin
        bus.i_valid = 1'b1; bus.i_alu_op = 5'd0;
        bus.i_op_a = 32'(i) * 32'd10; bus.i_op_b = 32'd1;
      end else bus.i_valid = 1'b0;
      @(posedge clk);
    end

    // Held request with changing operands while busy; chained ADD at o_valid
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = 5'd21; bus.i_op_a = 32'd100; bus.i_op_b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      bus.i_alu_op = codes[$urandom_range(0, 18)];
      bus.i_op_a = $urandom; bus.i_op_b = $urandom;
      @(negedge clk);
      lat++;
    end
    check("hold.lat", 64'(lat), 64'(XLEN + 1));
    check("hold.data", 64'(bus.o_alu_data), 64'd14);
    check("hold.ready", 64'(bus.o_ready), 64'd1);
    bus.i_alu_op = 5'd0; bus.i_op_a = 32'd10; bus.i_op_b = 32'd20;
    @(negedge clk);
    bus.i_valid = 1'b0;
    check("chain.valid", 64'(bus.o_valid), 64'd1);
    check("chain.data", 64'(bus.o_alu_data), 64'd30);

    // Reset in the middle of a divide
    @(negedge clk);
    bus.i_valid = 1'b1; bus.i_alu_op = 5'd20; bus.i_op_a = 32'd1000; bus.i_op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.ready", 64'(bus.o_ready), 64'd1);
    check("abort.busy", 64'(bus.o_busy), 64'd0);
    check("abort.data", 64'(bus.o_alu_data), 64'd0);
    vcount = 0;
    repeat (40) begin
      if (bus.o_valid) vcount++;
      @(negedge clk);
    end
    check("abort.no_valid", 64'(vcount), 64'd0);
    run_op(5'd0, 32'd2, 32'd3, 32'd5, "post_rst_add");

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      rop = codes[$urandom_range(0, 18)];
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = rb & 32'h0000001F;
        default: ;
      endcase
      run_op(rop, ra, rb, model(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
